plca_follower_rx: RTL and testbench

PLCA_FOLLOWER_RX -- requirements
Module: plca_follower_rx

---
 rtl/plca_follower_rx.sv | 145 ++++++++++++++
 tb/tb_plca_follower_rx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/plca_follower_rx.sv
// PLCA follower receive side: tracks BEACONs from the coordinator and steps the
// transmit-opportunity ID, flagging the local node's own opportunity.
module plca_follower_rx #(
   parameter int NODE_ID        = 1,
   parameter int NODE_COUNT     = 8,
   parameter int TO_TIMER       = 32,
   parameter int BEACON_TIMEOUT = 4000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx_dv,
   input  logic       rx_er,
   input  logic [3:0] rxd,
   input  logic       crs,
   output logic [7:0] cur_id,
   output logic       my_to,
   output logic       beacon_det,
   output logic       plca_status
);

   localparam int TOW = (TO_TIMER > 2) ? $clog2(TO_TIMER) : 1;
   localparam int BTW = $clog2(BEACON_TIMEOUT + 1);
   localparam logic [TOW-1:0] TO_LAST = TOW'(TO_TIMER - 1);
   localparam logic [BTW-1:0] BT_LAST = BTW'(BEACON_TIMEOUT - 1);
   localparam logic [BTW-1:0] BT_TOP  = BTW'(BEACON_TIMEOUT);
   localparam logic [7:0]     NC      = 8'(NODE_COUNT);
   localparam logic [7:0]     NID     = 8'(NODE_ID);

   typedef enum logic [1:0] {
      RESYNC    = 2'd0,
      WAIT_TO   = 2'd1,
      RECEIVE   = 2'd2,
      CYCLE_END = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       cur_id_q, cur_id_d;
   logic [TOW-1:0]   to_cnt_q, to_cnt_d;
   logic [BTW-1:0]   bto_cnt_q, bto_cnt_d;
   logic             status_q, status_d;
   logic             beacon_det_q, beacon_det_d;
   logic             bcn_seen_q, bcn_seen_d;
   logic             beacon_dec;
   logic             beacon_end;
   logic [7:0]       next_id;

   assign beacon_dec = (!rx_dv) && rx_er && (rxd == 4'h3);
   assign beacon_end = bcn_seen_q && !beacon_dec;
   assign next_id    = cur_id_q + 8'd1;

   // Next-state logic: BEACON end, then sync loss, then the opportunity walk.
   always_comb begin
      state_d      = state_q;
      cur_id_d     = cur_id_q;
      to_cnt_d     = to_cnt_q;
      bto_cnt_d    = bto_cnt_q;
      status_d     = status_q;
      beacon_det_d = 1'b0;
      bcn_seen_d   = beacon_dec;
      if (beacon_end) begin
         state_d      = WAIT_TO;
         cur_id_d     = 8'd0;
         to_cnt_d     = '0;
         bto_cnt_d    = '0;
         status_d     = 1'b1;
         beacon_det_d = 1'b1;
      end else if (status_q && (bto_cnt_q == BT_LAST)) begin
         state_d   = RESYNC;
         cur_id_d  = 8'd0;
         to_cnt_d  = '0;
         bto_cnt_d = BT_TOP;
         status_d  = 1'b0;
      end else begin
         if (status_q && (bto_cnt_q != BT_TOP)) begin
            bto_cnt_d = bto_cnt_q + BTW'(1);
         end else begin
            bto_cnt_d = bto_cnt_q;
         end
         case (state_q)
            RESYNC: begin
               cur_id_d = 8'd0;
               to_cnt_d = '0;
            end
            WAIT_TO: begin
               // Carrier wins over an expiring opportunity in the same clock.
               if (crs) begin
                  state_d  = RECEIVE;
                  to_cnt_d = '0;
               end else if (to_cnt_q == TO_LAST) begin
                  to_cnt_d = '0;
                  cur_id_d = next_id;
                  state_d  = (next_id == NC) ? CYCLE_END : WAIT_TO;
               end else begin
                  to_cnt_d = to_cnt_q + TOW'(1);
               end
            end
            RECEIVE: begin
               if (!crs) begin
                  to_cnt_d = '0;
                  cur_id_d = next_id;
                  state_d  = (next_id == NC) ? CYCLE_END : WAIT_TO;
               end else begin
                  to_cnt_d = '0;
               end
            end
            CYCLE_END: begin
               cur_id_d = NC;
               to_cnt_d = '0;
            end
            default: begin
               state_d  = RESYNC;
               cur_id_d = 8'd0;
               to_cnt_d = '0;
            end
         endcase
      end
   end

   // State and counter registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= RESYNC;
         cur_id_q     <= 8'd0;
         to_cnt_q     <= '0;
         bto_cnt_q    <= '0;
         status_q     <= 1'b0;
         beacon_det_q <= 1'b0;
         bcn_seen_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_id_q     <= cur_id_d;
         to_cnt_q     <= to_cnt_d;
         bto_cnt_q    <= bto_cnt_d;
         status_q     <= status_d;
         beacon_det_q <= beacon_det_d;
         bcn_seen_q   <= bcn_seen_d;
      end
   end

   assign cur_id      = cur_id_q;
   assign beacon_det  = beacon_det_q;
   assign plca_status = status_q;
   assign my_to       = (state_q == WAIT_TO) && (cur_id_q == NID);

endmodule

// File: tb/tb_plca_follower_rx.sv
// Directed bench for plca_follower_rx with hand-computed timeline expectations.
module tb_plca_follower_rx;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rx_dv;
   logic       rx_er;
   logic [3:0] rxd;
   logic       crs;
   logic [7:0] cur_id;
   logic       my_to;
   logic       beacon_det;
   logic       plca_status;

   int n_cmp = 0;
   int n_err = 0;
   int cnt;

   plca_follower_rx #(
      .NODE_ID(1), .NODE_COUNT(8), .TO_TIMER(32), .BEACON_TIMEOUT(4000)
   ) dut (
      .clk(clk), .reset_n(reset_n), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
      .crs(crs), .cur_id(cur_id), .my_to(my_to), .beacon_det(beacon_det),
      .plca_status(plca_status)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drives a BEACON for len clocks; afterwards sits one clock past BEACON end.
   task automatic beacon(input int len);
      int pulses;
      pulses = 0;
      rx_er = 1'b1;
      rxd   = 4'h3;
      for (int i = 0; i < len; i++) begin
         step(1);
         if (beacon_det) pulses++;
      end
      rx_er = 1'b0;
      rxd   = 4'h0;
      crs   = 1'b0;
      step(1);
      chk("bcn_det_pulse", beacon_det, 32'd1);
      chk("bcn_status", plca_status, 32'd1);
      chk("bcn_id0", cur_id, 32'd0);
      step(1);
      chk("bcn_det_single", beacon_det, 32'd0);
      chk("bcn_det_during", pulses, 32'd0);
   endtask

   initial begin
      reset_n = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; rxd = 4'h0; crs = 1'b0;
      step(3);
      chk("rst_id", cur_id, 32'd0);
      chk("rst_my_to", my_to, 32'd0);
      chk("rst_det", beacon_det, 32'd0);
      chk("rst_status", plca_status, 32'd0);

      // RESYNC ignores carrier and non-BEACON error codes
      reset_n = 1'b1; crs = 1'b1;
      step(20);
      chk("resync_crs_id", cur_id, 32'd0);
      chk("resync_status", plca_status, 32'd0);
      crs = 1'b0; rx_er = 1'b1; rxd = 4'h5;
      step(3);
      rx_er = 1'b0; rxd = 4'h0;
      step(2);
      chk("non_bcn_det", beacon_det, 32'd0);
      chk("non_bcn_status", plca_status, 32'd0);

      // Idle cycle: 32 clocks per ID, my_to for ID 1, CYCLE_END at 8
      beacon(2);
      step(30);
      chk("idle_id0_last", cur_id, 32'd0);
      step(1);
      chk("idle_id1", cur_id, 32'd1);
      chk("idle_my_to", my_to, 32'd1);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (my_to) cnt++;
         step(1);
      end
      chk("my_to_len", cnt, 32'd32);
      chk("idle_id2", cur_id, 32'd2);
      step(183);
      chk("idle_id7", cur_id, 32'd7);
      step(1);
      chk("cycle_end_id8", cur_id, 32'd8);
      step(50);
      chk("cycle_end_hold", cur_id, 32'd8);
      chk("cycle_end_my_to", my_to, 32'd0);
      chk("cycle_end_status", plca_status, 32'd1);

      // Carrier at clock 10 of ID 0 for 100 clocks
      beacon(2);
      step(9);
      crs = 1'b1;
      step(50);
      chk("rx_hold_mid", cur_id, 32'd0);
      step(50);
      chk("rx_hold_end", cur_id, 32'd0);
      chk("rx_my_to", my_to, 32'd0);
      crs = 1'b0;
      step(1);
      chk("rx_done_id1", cur_id, 32'd1);
      chk("rx_done_my_to", my_to, 32'd1);
      step(31);
      chk("to_restart_id1", cur_id, 32'd1);
      step(1);
      chk("to_restart_id2", cur_id, 32'd2);

      // Carrier coincides with TO expiry at ID 3
      step(32);
      chk("pre_exp_id3", cur_id, 32'd3);
      step(31);
      crs = 1'b1;
      step(1);
      chk("crs_prio_id3", cur_id, 32'd3);
      step(40);
      chk("crs_prio_hold", cur_id, 32'd3);
      crs = 1'b0;
      step(1);
      chk("crs_prio_id4", cur_id, 32'd4);

      // Long BEACON during carrier at ID 5
      step(32);
      chk("pre_bcn_id5", cur_id, 32'd5);
      crs = 1'b1;
      step(3);
      chk("rx_id5", cur_id, 32'd5);
      beacon(20);
      step(30);
      chk("post_rx_bcn_id0", cur_id, 32'd0);
      step(1);
      chk("post_rx_bcn_id1", cur_id, 32'd1);

      // Loss of BEACON for 4000 clocks
      step(3967);
      chk("pre_timeout_status", plca_status, 32'd1);
      chk("pre_timeout_id", cur_id, 32'd8);
      step(1);
      chk("timeout_status", plca_status, 32'd0);
      chk("timeout_id", cur_id, 32'd0);
      chk("timeout_my_to", my_to, 32'd0);
      beacon(2);

      // Reset asserted while receiving at ID 2
      step(63);
      chk("pre_rst_id2", cur_id, 32'd2);
      crs = 1'b1;
      step(5);
      chk("pre_rst_rx_id2", cur_id, 32'd2);
      reset_n = 1'b0;
      step(1);
      chk("midrst_id", cur_id, 32'd0);
      chk("midrst_status", plca_status, 32'd0);
      chk("midrst_my_to", my_to, 32'd0);
      reset_n = 1'b1; crs = 1'b0;
      step(100);
      chk("post_rst_id", cur_id, 32'd0);
      chk("post_rst_status", plca_status, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
